// File: rtl/firewall_enforcer.sv
// firewall_enforcer: holds one upstream transaction at a time, presents it to
// the external packet filter, and either forwards it downstream or drops it.
// A run of LOCK_THRESH consecutive violations blocks all traffic for
// LOCK_CYCLES cycles, or until clr_lock ends the lockdown early.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Once m_valid is raised it stays high, with m_* unchanged, until
// that transfer; s_ready is high only while the block is idle.
module firewall_enforcer #(
    parameter int LOCK_THRESH = 4,
    parameter int LOCK_CYCLES = 256,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [15:0]      s_addr,
    input  logic [3:0]       s_cmd,
    input  logic [31:0]      s_data,
    output logic [15:0]      f_addr,
    output logic [3:0]       f_cmd,
    output logic [31:0]      f_data,
    input  logic             f_violation,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [15:0]      m_addr,
    output logic [3:0]       m_cmd,
    output logic [31:0]      m_data,
    output logic             drop_pulse,
    output logic             lockdown,
    output logic [CNT_W-1:0] viol_count,
    input  logic             clr_lock,
    output logic [2:0]       dbg_state
);

    localparam int STRIKE_W = $clog2(LOCK_THRESH + 1);
    localparam int TIMER_W  = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        JUDGE   = 3'd2,
        FORWARD = 3'd3,
        LOCK    = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [15:0]         h_addr;
    logic [3:0]          h_cmd;
    logic [31:0]         h_data;
    logic [STRIKE_W-1:0] strikes;
    logic [STRIKE_W-1:0] strike_new;
    logic [TIMER_W-1:0]  timer;
    logic                judge_viol;
    logic                lock_hit;
    logic                lock_exit;

    // The filter and the downstream port both see the held copy.
    assign f_addr    = h_addr;
    assign f_cmd     = h_cmd;
    assign f_data    = h_data;
    assign m_addr    = h_addr;
    assign m_cmd     = h_cmd;
    assign m_data    = h_data;
    assign s_ready   = (state == IDLE);
    assign m_valid   = (state == FORWARD);
    assign lockdown  = (state == LOCK);
    assign dbg_state = state;

    // Next-state decode plus the strike/lock decisions taken in JUDGE.
    always_comb begin
        state_next = state;
        judge_viol = (state == JUDGE) && f_violation;
        // A clr_lock that lands on a violating verdict still counts that strike.
        strike_new = clr_lock ? STRIKE_W'(1) : strikes + STRIKE_W'(1);
        lock_hit   = judge_viol && (strike_new == STRIKE_W'(LOCK_THRESH));
        lock_exit  = 1'b0;
        case (state)
            IDLE:    if (s_valid) state_next = CHECK;
            CHECK:   state_next = JUDGE;
            JUDGE: begin
                if (!f_violation) state_next = FORWARD;
                else if (lock_hit) state_next = LOCK;
                else               state_next = IDLE;
            end
            FORWARD: if (m_ready) state_next = IDLE;
            LOCK: begin
                if (clr_lock || timer == TIMER_W'(1)) begin
                    state_next = IDLE;
                    lock_exit  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Hold registers, drop pulse, violation counter, strike count and lock timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_addr     <= '0;
            h_cmd      <= '0;
            h_data     <= '0;
            drop_pulse <= 1'b0;
            viol_count <= '0;
            strikes    <= '0;
            timer      <= '0;
        end else begin
            if (s_valid && s_ready) begin
                h_addr <= s_addr;
                h_cmd  <= s_cmd;
                h_data <= s_data;
            end
            drop_pulse <= judge_viol;
            if (judge_viol && viol_count != {CNT_W{1'b1}})
                viol_count <= viol_count + CNT_W'(1);
            if (state == JUDGE)
                strikes <= f_violation ? strike_new : '0;
            else if (clr_lock || lock_exit)
                strikes <= '0;
            if (lock_hit)
                timer <= TIMER_W'(LOCK_CYCLES);
            else if (state == LOCK)
                timer <= lock_exit ? '0 : timer - TIMER_W'(1);
        end
    end

endmodule

// File: tb/tb_firewall_enforcer.sv
// Bench for firewall_enforcer: a registered packet filter model, a driver,
// a scoreboard monitor fed by an expected queue, and a final report.
module tb_firewall_enforcer;

    localparam int LOCK_THRESH = 4;
    localparam int LOCK_CYCLES = 256;
    localparam int CNT_W       = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [15:0]      s_addr = '0;
    logic [3:0]       s_cmd = '0;
    logic [31:0]      s_data = '0;
    logic [15:0]      f_addr;
    logic [3:0]       f_cmd;
    logic [31:0]      f_data;
    logic             f_violation;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [15:0]      m_addr;
    logic [3:0]       m_cmd;
    logic [31:0]      m_data;
    logic             drop_pulse;
    logic             lockdown;
    logic [CNT_W-1:0] viol_count;
    logic             clr_lock = 1'b0;
    logic [2:0]       dbg_state;

    int          n_checks = 0;
    int          n_fails = 0;
    logic [52:0] exp_q[$];      // {dropped, addr, cmd, data}
    int          model_cnt = 0;
    int          model_strikes = 0;
    bit          rand_ready_en = 1'b0;
    bit          last_viol;
    bit          last_lock;

    firewall_enforcer #(
        .LOCK_THRESH(LOCK_THRESH), .LOCK_CYCLES(LOCK_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_addr(s_addr), .s_cmd(s_cmd), .s_data(s_data),
        .f_addr(f_addr), .f_cmd(f_cmd), .f_data(f_data), .f_violation(f_violation),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_cmd(m_cmd),
        .m_data(m_data), .drop_pulse(drop_pulse), .lockdown(lockdown),
        .viol_count(viol_count), .clr_lock(clr_lock), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- filter rules ----------------
    function automatic bit rule_viol(input logic [15:0] a, input logic [3:0] c,
                                     input logic [31:0] d);
        return (d == 32'hDEADBEEF) || (a == 16'h0000) ||
               (c == 4'd2 && a == 16'h1234);
    endfunction

    // Filter registers its verdict one cycle after seeing f_*.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) f_violation <= 1'b0;
        else        f_violation <= rule_viol(f_addr, f_cmd, f_data);
    end

    // Random downstream backpressure, changed away from the sampling edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready_en) m_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic report_and_stop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $fatal(1, "bench stopped on timeout");
    endtask

    // ---------------- driver ----------------
    // Issues one transaction, updates the reference model, and checks the
    // cycle-accurate response up to handshake+3.
    task automatic send(input logic [15:0] a, input logic [3:0] c, input logic [31:0] d);
        int waited = 0;
        @(negedge clk);
        while (!s_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            n_checks++;
            n_fails++;
            $display("FAIL send_timeout: s_ready still 0 after %0d cycles", waited);
            report_and_stop();
        end
        s_addr  = a;
        s_cmd   = c;
        s_data  = d;
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        last_viol = rule_viol(a, c, d);
        last_lock = 1'b0;
        if (last_viol) begin
            if (model_cnt < (1 << CNT_W) - 1) model_cnt++;
            model_strikes++;
            if (model_strikes == LOCK_THRESH) begin
                last_lock = 1'b1;
                model_strikes = 0;
            end
        end else begin
            model_strikes = 0;
        end
        exp_q.push_back({last_viol, a, c, d});
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            chk("busy_s_ready", s_ready, 0);
            chk("busy_m_valid", m_valid, 0);
            chk("busy_drop", drop_pulse, 0);
        end
        @(negedge clk);
        chk("n3_m_valid", m_valid, !last_viol);
        chk("n3_drop", drop_pulse, last_viol);
        chk("n3_lockdown", lockdown, last_lock);
        chk("n3_s_ready", s_ready, last_viol && !last_lock);
        chk("n3_viol_count", viol_count, model_cnt);
    endtask

    task automatic pulse_clr();
        clr_lock = 1'b1;
        @(posedge clk);
        #1 clr_lock = 1'b0;
        model_strikes = 0;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic        prev_stall = 1'b0;
    logic [51:0] prev_fields = '0;

    task automatic pop_cmp(input logic dropped);
        logic [52:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_output: dropped=%0b addr=0x%0h with empty queue", dropped, m_addr);
        end else begin
            e = exp_q.pop_front();
            chk("out_txn", {11'd0, dropped, m_addr, m_cmd, m_data}, {11'd0, e});
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_fields", {m_addr, m_cmd, m_data}, prev_fields);
            end
            if (m_valid && m_ready) pop_cmp(1'b0);
            if (drop_pulse)         pop_cmp(1'b1);
            prev_stall  = m_valid && !m_ready;
            prev_fields = {m_addr, m_cmd, m_data};
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int lock_len;
        int drain;
        logic [15:0] ra;
        logic [3:0]  rc;
        logic [31:0] rd;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_lockdown", lockdown, 0);
        chk("rst_viol_count", viol_count, 0);
        chk("rst_fields", {m_addr, m_cmd, m_data, f_addr}, 0);
        rst_n = 1'b1;

        // Clean transaction and data-rule violation
        send(16'h0100, 4'd1, 32'h12345678);
        send(16'h0100, 4'd1, 32'hDEADBEEF);
        chk("data_rule_count", viol_count, 1);

        // Strike reset: 3 violations, 1 clean, 3 violations -> no lockdown
        send(16'h0200, 4'd3, 32'h0);
        for (int i = 0; i < 3; i++) send(16'h0000, 4'd0, 32'h1);
        send(16'h0300, 4'd1, 32'h5);
        for (int i = 0; i < 3; i++) send(16'h1234, 4'd2, 32'h2);
        chk("strike_reset_count", viol_count, 7);
        send(16'h0400, 4'd1, 32'h6);

        // Lockdown after four back-to-back violations, timed exit
        send(16'h0000, 4'd1, 32'h0);
        send(16'h1234, 4'd2, 32'h0);
        send(16'h0000, 4'd5, 32'h0);
        send(16'h1234, 4'd2, 32'hFF);
        chk("lock_entered", lockdown, 1);
        lock_len = 1;
        while (lock_len < 1000) begin
            @(negedge clk);
            if (!lockdown) break;
            chk("lock_s_ready", s_ready, 0);
            lock_len++;
        end
        chk("lock_len", lock_len, LOCK_CYCLES);
        chk("lock_exit_s_ready", s_ready, 1);
        chk("lock_count", viol_count, 11);
        // Strikes were cleared on exit: three more violations do not lock
        for (int i = 0; i < 3; i++) send(16'h0000, 4'd0, 32'h0);

        // clr_lock outside lockdown clears strikes
        pulse_clr();
        for (int i = 0; i < 3; i++) send(16'h0000, 4'd0, 32'h0);
        pulse_clr();

        // Early exit with clr_lock ten cycles into lockdown
        for (int i = 0; i < 4; i++) send(16'h0000, 4'd1, 32'h0);
        repeat (9) @(negedge clk);
        chk("clr_still_locked", lockdown, 1);
        pulse_clr();
        @(negedge clk);
        chk("clr_lockdown", lockdown, 0);
        chk("clr_s_ready", s_ready, 1);

        // Backpressure: m_ready low for five cycles of m_valid
        m_ready = 1'b0;
        send(16'h0A0A, 4'd7, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_m_valid", m_valid, 1);
            chk("bp_s_ready", s_ready, 0);
            chk("bp_fields", {m_addr, m_cmd, m_data}, {16'h0A0A, 4'd7, 32'hCAFEF00D});
        end
        @(posedge clk);
        #2 m_ready = 1'b1;
        @(negedge clk);
        chk("bp_last_valid", m_valid, 1);
        @(negedge clk);
        chk("bp_idle_s_ready", s_ready, 1);
        chk("bp_idle_m_valid", m_valid, 0);

        // Randomized traffic with random backpressure
        rand_ready_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom_range(1, 16'hFFFF));
            rc = 4'($urandom_range(0, 15));
            rd = $urandom;
            case ($urandom_range(0, 9))
                0, 1:    ra = 16'h0000;
                2:       rd = 32'hDEADBEEF;
                3:       begin ra = 16'h1234; rc = 4'd2; end
                default: ;
            endcase
            send(ra, rc, rd);
        end
        rand_ready_en = 1'b0;
        @(posedge clk);
        #2 m_ready = 1'b1;
        drain = 0;
        while (exp_q.size() != 0 && drain < 400) begin
            @(negedge clk);
            drain++;
        end
        chk("drain_random", exp_q.size(), 0);

        // Reset while a clean transaction waits in FORWARD
        m_ready = 1'b0;
        send(16'h0B0B, 4'd1, 32'h0BADF00D);
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_viol_count", viol_count, 0);
        chk("midrst_drop", drop_pulse, 0);
        chk("midrst_s_ready", s_ready, 1);
        chk("midrst_fields", {m_addr, m_cmd, m_data}, 0);
        exp_q.delete();
        model_cnt = 0;
        model_strikes = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        send(16'h0C0C, 4'd1, 32'h11112222);
        send(16'h0000, 4'd1, 32'h11112222);
        repeat (3) @(negedge clk);
        chk("final_drain", exp_q.size(), 0);
        chk("final_count", viol_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/firewall_enforcer.md
# firewall_enforcer

Transaction gate on the initiator-to-target path. Accepts upstream bus transactions (addr/cmd/data), presents each to the rule-checking packet filter, and waits for its registered verdict. Clean transactions go downstream; violating ones are dropped and counted. A run of consecutive violations triggers a timed lockdown. The block drives the filter's inputs and consumes its `rule_violation` output.

## Interface
- `LOCK_THRESH`, default 4: consecutive violations that trigger lockdown (≥1).
- `LOCK_CYCLES`, default 256: lockdown duration in cycles (≥1).
- `CNT_W`, default 16: width of the violation counter.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: upstream transaction valid.
- `s_ready` out 1: block can accept a transaction.
- `s_addr` in 16, `s_cmd` in 4, `s_data` in 32: upstream transaction fields.
- `f_addr` out 16, `f_cmd` out 4, `f_data` out 32: held transaction, presented to the filter.
- `f_violation` in 1: filter verdict, registered by the filter one cycle after `f_*`.
- `m_valid` out 1: downstream transaction valid.
- `m_ready` in 1: downstream accept.
- `m_addr` out 16, `m_cmd` out 4, `m_data` out 32: downstream transaction fields (the held copy).
- `drop_pulse` out 1: one-cycle pulse per dropped transaction.
- `lockdown` out 1: high while in LOCK.
- `viol_count` out CNT_W: total violations since reset, saturating.
- `clr_lock` in 1: exits LOCK early and clears the strike count.

## Operation
- Hold registers `h_addr`/`h_cmd`/`h_data` load on `s_valid && s_ready`.
- `f_*` and `m_*` are driven directly from the hold registers.
- Strike counter: width $clog2(LOCK_THRESH+1). Lockdown timer: width $clog2(LOCK_CYCLES+1).
- FSM states: IDLE, CHECK, JUDGE, FORWARD, LOCK.
  - IDLE: `s_ready`=1. On handshake, capture into hold registers and go to CHECK.
  - CHECK: filter samples `f_*` at the end of this cycle. Go to JUDGE unconditionally.
  - JUDGE: sample `f_violation`.
    - 0: clear strikes, go to FORWARD.
    - 1: `drop_pulse`<=1, `viol_count`+=1 (saturate at all-ones), strikes+=1.
    - 1 with new strike count == LOCK_THRESH: load timer with LOCK_CYCLES, go to LOCK.
    - 1 otherwise: go to IDLE.
  - FORWARD: `m_valid`=1. Hold `m_*` stable until `m_ready`. On `m_valid && m_ready`, go to IDLE.
  - LOCK: `s_ready`=0, `lockdown`=1, timer decrements each cycle. Go to IDLE when the timer reaches 1 or when `clr_lock` is sampled high. On exit, clear strikes. `viol_count` is not cleared.
- `clr_lock` outside LOCK clears strikes only. When it coincides with a violating JUDGE, the violation is counted and strikes end at 1.
- `s_ready` is 0 in every state except IDLE. No transaction is accepted during CHECK, JUDGE, FORWARD or LOCK.
- `m_valid` is never asserted for a dropped transaction.
- `f_violation` is ignored outside JUDGE.

## Timing
- Reset values:
  - state IDLE, so `s_ready`=1;
  - `m_valid`=0, `drop_pulse`=0, `lockdown`=0, `viol_count`=0;
  - strikes=0, timer=0;
  - hold registers and `f_*`/`m_*` = 0.
- Handshake at edge N: CHECK in cycle N+1, JUDGE in N+2.
  - Clean transaction: `m_valid` high in N+3 (3-cycle latency).
  - Violation: `drop_pulse` high in N+3 only.
- Best-case throughput with `m_ready`=1: one transaction per 4 cycles. Next `s_ready` in N+4.
- Lockdown:
  - `lockdown` rises in N+3, together with `drop_pulse`.
  - It stays high exactly LOCK_CYCLES cycles; `s_ready` returns the following cycle.
  - If `clr_lock` is sampled at edge E, `lockdown`=0 and `s_ready`=1 in the cycle after E.
- Backpressure: `m_*` unchanged while `m_valid && !m_ready`, for any number of cycles.
- Reset mid-operation, in any state: return to IDLE immediately. The held transaction is discarded, with no `m_valid` and no `drop_pulse`.

## Test plan
- Clean transaction: `s_addr`=0x0100, `s_cmd`=1, `s_data`=0x12345678, `m_ready`=1 -> `m_valid` 3 cycles after the handshake with the identical fields; `viol_count`=0; `drop_pulse` never high.
- Data rule: `s_data`=0xDEADBEEF, `s_addr`=0x0100 -> no `m_valid`; `drop_pulse` one cycle at handshake+3; `viol_count`=1.
- Lockdown: four back-to-back violations (`s_addr`=0x0000, or `s_cmd`=2 with `s_addr`=0x1234) -> `lockdown` rises with the 4th `drop_pulse`; `s_ready`=0 for exactly 256 cycles; `viol_count`=4; strikes cleared on exit.
- Strike reset: 3 violations, 1 clean, 3 violations -> no lockdown; `viol_count`=6.
- Backpressure: clean transaction with `m_ready` held low for 5 cycles -> `m_valid` and `m_*` stable for 6 cycles; `s_ready` low throughout; IDLE after the handshake.
- Early exit and reset:
  - `clr_lock` pulsed 10 cycles into lockdown -> `lockdown` low and `s_ready` high next cycle.
  - `rst_n` asserted during FORWARD -> `m_valid`=0 immediately and `viol_count`=0.
